// File: rtl/cmp_arbiter.sv
// Two-requester arbiter sharing one external equality comparator; optional macro CMP_ARB_FIXED_PRIO_EN.
// Latency: request accepted in cycle N, response valid at N+2, back in IDLE at N+3 if rsp_ready is high.
// Backpressure: one request in flight; both req ready stay low until the owner's response is consumed.
module cmp_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic             rsp0_eq,
  input  logic             rsp0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic             rsp1_eq,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_y,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t           state_q;
  logic             owner_q;       // 1 = requester 1 owns the transaction in flight
  logic             last_grant_q;  // requester granted most recently
  logic [WIDTH-1:0] cmp_a_q, cmp_b_q;
  logic [WIDTH-1:0] cmp_a_d, cmp_b_d;
  logic             rsp0_valid_q, rsp0_eq_q;
  logic             rsp1_valid_q, rsp1_eq_q;
  logic             idle;
  logic             win1;
  logic             hs0, hs1;
  logic             owner_rsp_ready;

  assign idle = (state_q == IDLE);

`ifdef CMP_ARB_FIXED_PRIO_EN
  // Requester 0 always wins a tie; history is ignored.
  assign win1 = req1_valid & ~req0_valid;
`else
  // Round-robin: requester 1 wins a tie only if requester 0 was granted last.
  assign win1 = req1_valid & (~req0_valid | ~last_grant_q);
`endif

  assign req0_ready = idle & req0_valid & ~win1;
  assign req1_ready = idle & win1;
  assign hs0        = req0_valid & req0_ready;
  assign hs1        = req1_valid & req1_ready;

  // Operand pair of whichever requester wins this cycle.
  assign cmp_a_d = win1 ? req1_a : req0_a;
  assign cmp_b_d = win1 ? req1_b : req0_b;

  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  assign cmp_a      = cmp_a_q;
  assign cmp_b      = cmp_b_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_eq    = rsp0_eq_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_eq    = rsp1_eq_q;
  assign busy       = ~idle;

  // Transaction FSM: accept, sample comparator, hold response until consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cmp_a_q      <= '0;
      cmp_b_q      <= '0;
      rsp0_valid_q <= 1'b0;
      rsp0_eq_q    <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_eq_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs0 | hs1) begin
            cmp_a_q      <= cmp_a_d;
            cmp_b_q      <= cmp_b_d;
            owner_q      <= hs1;
            last_grant_q <= hs1;
            state_q      <= COMPARE;
          end
        end
        COMPARE: begin
          if (owner_q) begin
            rsp1_eq_q    <= cmp_y;
            rsp1_valid_q <= 1'b1;
          end else begin
            rsp0_eq_q    <= cmp_y;
            rsp0_valid_q <= 1'b1;
          end
          state_q <= RESPOND;
        end
        RESPOND: begin
          if (owner_rsp_ready) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Randomized and directed bench for cmp_arbiter with an in-bench transaction model.
// Model tracks at most one in-flight request by age; outputs are compared every negedge.
// Directed sections pin the model with literal expectations for the key scenarios.
module tb_cmp_arbiter;

  localparam int W = 32;

  logic         clk;
  logic         reset_n;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         rsp0_valid, rsp0_eq, rsp0_ready;
  logic         rsp1_valid, rsp1_eq, rsp1_ready;
  logic [W-1:0] cmp_a, cmp_b;
  logic         cmp_y;
  logic         busy;

  int checks = 0;
  int errors = 0;

  cmp_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_eq(rsp0_eq), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_eq(rsp1_eq), .rsp1_ready(rsp1_ready),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_y(cmp_y), .busy(busy)
  );

  // The shared comparator is outside the DUT.
  assign cmp_y = (cmp_a == cmp_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit           m_out;      // a request is in flight
  int           m_age;      // edges since acceptance (1 = comparing, >=2 = responding)
  bit           m_owner;
  bit           m_eq;
  bit           m_last;
  logic [W-1:0] m_cmp_a, m_cmp_b;
  bit           s_hs0, s_hs1, s_rr0, s_rr1;
  logic [W-1:0] s_a, s_b;
  bit           grants[$];

  always @(posedge clk or negedge clk) begin
    if (!clk) begin
      if (!reset_n) begin
        m_out = 0; m_age = 0; m_owner = 0; m_eq = 0; m_last = 1;
        m_cmp_a = '0; m_cmp_b = '0;
        s_hs0 = 0; s_hs1 = 0; s_rr0 = 0; s_rr1 = 0;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_rsp0_valid", {31'd0, rsp0_valid}, 0);
        check("rst_rsp1_valid", {31'd0, rsp1_valid}, 0);
        check("rst_rsp0_eq", {31'd0, rsp0_eq}, 0);
        check("rst_rsp1_eq", {31'd0, rsp1_eq}, 0);
        check("rst_cmp_a", cmp_a, '0);
        check("rst_cmp_b", cmp_b, '0);
      end else begin
        int  win;   // -1 none, else requester index
        bit  rv0, rv1;
        win = -1;
        if (!m_out) begin
          if (req0_valid && req1_valid) begin
`ifdef CMP_ARB_FIXED_PRIO_EN
            win = 0;
`else
            win = m_last ? 0 : 1;
`endif
          end else if (req0_valid) win = 0;
          else if (req1_valid) win = 1;
        end
        rv0 = m_out && !m_owner && m_age >= 2;
        rv1 = m_out &&  m_owner && m_age >= 2;
        check("busy", {31'd0, busy}, {31'd0, m_out});
        check("req0_ready", {31'd0, req0_ready}, {31'd0, win == 0});
        check("req1_ready", {31'd0, req1_ready}, {31'd0, win == 1});
        check("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, rv0});
        check("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, rv1});
        if (rv0) check("rsp0_eq", {31'd0, rsp0_eq}, {31'd0, m_eq});
        if (rv1) check("rsp1_eq", {31'd0, rsp1_eq}, {31'd0, m_eq});
        check("cmp_a", cmp_a, m_cmp_a);
        check("cmp_b", cmp_b, m_cmp_b);
        s_hs0 = (win == 0);
        s_hs1 = (win == 1);
        s_a   = (win == 1) ? req1_a : req0_a;
        s_b   = (win == 1) ? req1_b : req0_b;
        s_rr0 = rsp0_ready;
        s_rr1 = rsp1_ready;
      end
    end else if (reset_n) begin
      if (m_out) begin
        if (m_age >= 2 && (m_owner ? s_rr1 : s_rr0)) m_out = 0;
        else m_age++;
      end else if (s_hs0 || s_hs1) begin
        m_out   = 1;
        m_age   = 1;
        m_owner = s_hs1;
        m_last  = s_hs1;
        m_eq    = (s_a == s_b);
        m_cmp_a = s_a;
        m_cmp_b = s_b;
        grants.push_back(s_hs1);
      end
      s_hs0 = 0; s_hs1 = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    rsp0_ready = 1; rsp1_ready = 1;
  endtask

  initial begin
    bit exp_g[4];
    reset_n = 0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    idle_inputs();
    repeat (3) step();
    reset_n = 1;
    step();

    // Single equal request from requester 0.
    req0_valid = 1; req0_a = 32'h0000_1234; req0_b = 32'h0000_1234;
    #3 check("t1_ready_N", {31'd0, req0_ready}, 1);
    step(); req0_valid = 0;
    step(); #3;
    check("t1_rsp_valid_N2", {31'd0, rsp0_valid}, 1);
    check("t1_rsp_eq_N2", {31'd0, rsp0_eq}, 1);
    step(); #3 check("t1_idle_N3", {31'd0, busy}, 0);
    step();

    // Unequal request from requester 1.
    req1_valid = 1; req1_a = 32'hFFFF_FFFF; req1_b = 32'h7FFF_FFFF;
    step(); req1_valid = 0;
    step(); #3;
    check("t2_rsp1_valid", {31'd0, rsp1_valid}, 1);
    check("t2_rsp1_eq", {31'd0, rsp1_eq}, 0);
    check("t2_rsp0_valid", {31'd0, rsp0_valid}, 0);
    repeat (2) step();

    // Contention: both valid for four transactions.
    grants.delete();
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 12; i++) begin
      req0_a = $urandom; req0_b = (i % 2) ? req0_a : $urandom;
      req1_a = $urandom; req1_b = (i % 3) ? req1_a : $urandom;
      step();
    end
    idle_inputs();
    repeat (3) step();
`ifdef CMP_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    check("t3_num_grants", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      check($sformatf("t3_grant%0d", i), {31'd0, grants[i]}, {31'd0, exp_g[i]});

    // Backpressure on requester 0 with requester 1 waiting.
    req0_valid = 1; req0_a = 32'hCAFE_0001; req0_b = 32'hCAFE_0001; rsp0_ready = 0;
    step(); req0_valid = 0; req1_valid = 1; req1_a = 32'h55; req1_b = 32'h55;
    step();
    for (int i = 0; i < 5; i++) begin
      #3;
      check("t4_hold_valid", {31'd0, rsp0_valid}, 1);
      check("t4_hold_eq", {31'd0, rsp0_eq}, 1);
      check("t4_req1_blocked", {31'd0, req1_ready}, 0);
      step();
    end
    rsp0_ready = 1;
    #3 check("t4_still_valid", {31'd0, rsp0_valid}, 1);
    step(); #3;
    check("t4_done", {31'd0, rsp0_valid}, 0);
    check("t4_req1_now", {31'd0, req1_ready}, 1);
    step(); req1_valid = 0;
    repeat (3) step();

    // Reset while comparing.
    req0_valid = 1; req0_a = 32'hA5A5_A5A5; req0_b = 32'h0;
    step(); req0_valid = 0;
    reset_n = 0;
    #1;
    check("t5_busy", {31'd0, busy}, 0);
    check("t5_rsp0_valid", {31'd0, rsp0_valid}, 0);
    check("t5_cmp_a", cmp_a, '0);
    step(); step();
    reset_n = 1;
    req1_valid = 1; req1_a = 32'h77; req1_b = 32'h77;
    #3 check("t5_req1_accept", {31'd0, req1_ready}, 1);
    step(); req1_valid = 0;
    step(); #3 check("t5_rsp1_valid", {31'd0, rsp1_valid}, 1);
    repeat (2) step();

    // Operand hold after handshake.
    req0_valid = 1; req0_a = 32'h1111_2222; req0_b = 32'h3;
    step(); req0_valid = 0; req0_a = 32'hDEAD_BEEF;
    step(); req0_a = 32'h0BAD_F00D;
    #3 check("t6_cmp_a_hold", cmp_a, 32'h1111_2222);
    repeat (4) step();
    check("t6_cmp_a_idle", cmp_a, 32'h1111_2222);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_a = $urandom; req0_b = $urandom_range(0, 1) ? req0_a : $urandom;
      req1_a = $urandom; req1_b = $urandom_range(0, 1) ? req1_a : $urandom;
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    idle_inputs();
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 clk  input  1  sole clock, rising-edge active.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 (decode branch unit) has an operand pair.
REQ-005 req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-006 req0_ready  output  1  requester 0 pair accepted this cycle when high with req0_valid.
REQ-007 rsp0_valid  output  1  requester 0 result available.
REQ-008 rsp0_eq  output  1  requester 0 result, 1 = operands equal.
REQ-009 rsp0_ready  input  1  requester 0 consumes result.
REQ-010 req1_valid, req1_a, req1_b, req1_ready, rsp1_valid, rsp1_eq, rsp1_ready: same widths and meanings for requester 1 (watchpoint unit).
REQ-011 cmp_a, cmp_b  output  WIDTH  operands driven to the shared equality comparator.
REQ-012 cmp_y  input  1  comparator result, combinational from cmp_a/cmp_b.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, COMPARE and RESPOND.
REQ-015 In IDLE, the block SHALL assert reqN_ready combinationally for exactly one requester: the arbitration winner among those with reqN_valid high. It SHALL assert no ready when no requester is valid.
REQ-016 With both requesters valid, the winner SHALL be the requester not granted most recently (round-robin).
REQ-017 On a handshake (valid && ready) in cycle N, the block SHALL latch the operands into cmp_a/cmp_b registers, record the grant owner, update last_grant, and enter COMPARE at N+1.
REQ-018 In COMPARE, the block SHALL register cmp_y into the owner's rspN_eq, set rspN_valid, and enter RESPOND. The response is visible at cycle N+2.
REQ-019 In RESPOND, rspN_valid and rspN_eq SHALL hold stable until rspN_ready is high at a rising edge. At that edge, rspN_valid SHALL clear and the FSM SHALL return to IDLE.
REQ-020 Only one request SHALL be outstanding at a time. Both reqN_ready SHALL be low outside IDLE.
REQ-021 The non-owner's rsp_valid SHALL remain low throughout a transaction.
REQ-022 cmp_a/cmp_b SHALL change only on an accepted handshake.
REQ-023 The minimum throughput SHALL be one compare per 3 cycles, when rsp_ready is already high in RESPOND.
REQ-024 If reqN_valid drops in IDLE without a handshake, no state change SHALL occur.

Reset
REQ-025 Asserting reset_n low SHALL immediately, asynchronously, force:
- the FSM to IDLE;
- rsp0_valid, rsp1_valid, rsp0_eq, rsp1_eq to 0;
- cmp_a, cmp_b to 0;
- busy to 0;
- last_grant to 1, so requester 0 wins the first tie.
REQ-026 Reset during COMPARE or RESPOND SHALL discard the in-flight transaction with no response delivered.
REQ-027 Operation SHALL resume on the first rising clk edge after reset_n deasserts.

Configuration
REQ-028 Macro CMP_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win simultaneous requests, and last_grant SHALL have no effect.
REQ-029 When CMP_ARB_FIXED_PRIO_EN is not defined, round-robin per REQ-016 applies.

Verification
REQ-030 Single request: req0 a=0x0000_1234, b=0x0000_1234, rsp0_ready=1. Required: req0_ready at N, rsp0_valid=1 and rsp0_eq=1 at N+2, back in IDLE at N+3.
REQ-031 Inequality: req1 a=0xFFFF_FFFF, b=0x7FFF_FFFF. Required: rsp1_eq=0 at N+2; rsp0_valid stays 0 throughout.
REQ-032 Contention, macro undefined: both valid continuously for 4 transactions. Required: grants 0,1,0,1. With the macro defined, required grants 0,0,0,0.
REQ-033 Backpressure: rsp0_ready=0 for 5 cycles after rsp0_valid rises. Required:
- rsp0_valid/rsp0_eq stay stable;
- req1_ready stays 0 even with req1_valid=1;
- completion occurs on the edge where rsp0_ready=1.
REQ-034 Reset mid-operation: reset_n low during COMPARE. Required: immediately busy=0, rsp0_valid=0, cmp_a=0; after release, a new req1 is accepted normally.
REQ-035 Operand hold: change req0_a after the handshake. Required: cmp_a retains the latched value until the next handshake.
